mips_fetch_unit: RTL and testbench

Instruction-fetch stage of the multi-cycle MIPS core, directly upstream of the control/decode unit. Holds the program counter, reads one instruction word per fetch over a waitrequest-style memory bus, and presents it to the control unit with a valid/ready handshake. Applies jump/branch redirects with one architectural delay slot and halts after a jump to address 0.

---
 rtl/mips_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_mips_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Instruction-fetch stage of the multi-cycle MIPS core. Holds the program
// counter and reads one instruction word per fetch over a waitrequest-style
// memory bus. It hands each word to the control unit with a valid/ready
// handshake and applies taken jumps/branches after one architectural delay
// slot. A jump to address 0 halts the unit until the next reset.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   mem_address      fetch byte address (always the pc)
//   mem_read         read request, high only while fetching
//   mem_waitrequest  memory not ready; a read completes when this is low
//   mem_readdata     instruction word, captured when the read completes
//   instr_valid      instr/instr_pc hold a fetched instruction
//   instr_ready      control unit accepts the instruction this cycle
//   instr            fetched instruction word
//   opcode           instr[31:26]
//   instr_pc         address the instruction was fetched from
//   redirect_valid   accepted instruction is a taken jump/branch
//   redirect_target  jump/branch target byte address
//   active           high while fetching or issuing
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        pending_q;
  logic [31:0] pending_target_q;

  // Handshake outputs are registered alongside the state so that no input
  // reaches an output combinationally.
  logic        mem_read_q;
  logic        instr_valid_q;
  logic        active_q;

  logic        read_done;
  logic        accept;
  logic [31:0] pc_plus4;

  assign read_done = mem_read_q & ~mem_waitrequest;
  assign accept    = instr_valid_q & instr_ready;
  assign pc_plus4  = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      pc_q             <= RESET_VECTOR;
      instr_q          <= '0;
      instr_pc_q       <= '0;
      pending_q        <= 1'b0;
      pending_target_q <= '0;
      mem_read_q       <= 1'b0;
      instr_valid_q    <= 1'b0;
      active_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          mem_read_q <= 1'b1;
          active_q   <= 1'b1;
        end

        FETCH: begin
          // pc is untouched here, so the address holds through wait states.
          if (read_done) begin
            instr_q       <= mem_readdata;
            instr_pc_q    <= pc_q;
            state_q       <= ISSUE;
            mem_read_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end

        ISSUE: begin
          if (accept) begin
            instr_valid_q <= 1'b0;
            if (pending_q) begin
              // Delay slot just left: take the saved target, or halt on 0.
              // Any redirect flagged on the slot itself is dropped.
              pending_q <= 1'b0;
              if (pending_target_q == '0) begin
                state_q  <= HALTED;
                active_q <= 1'b0;
              end else begin
                pc_q       <= pending_target_q;
                state_q    <= FETCH;
                mem_read_q <= 1'b1;
              end
            end else begin
              // Fall through to the delay slot first; the target waits.
              pc_q       <= pc_plus4;
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
              if (redirect_valid) begin
                pending_q        <= 1'b1;
                pending_target_q <= redirect_target & 32'hFFFF_FFFC;
              end
            end
          end
        end

        HALTED: begin
          // Terminal until reset.
        end

        default: begin
          state_q       <= IDLE;
          mem_read_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          active_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address = pc_q;
  assign mem_read    = mem_read_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_pc    = instr_pc_q;
  assign active      = active_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit
// Directed scenarios followed by a randomized run of mips_fetch_unit. Every
// cycle is checked against a reference model. The model tracks the expected
// program order: the next fetch address, plus a queue of deferred
// jump targets that take effect after their delay slot. Bus timing is
// derived from what was driven and observed in the previous cycle.
module tb_mips_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        active;

  mips_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata   (mem_readdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opcode         (opcode),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .active         (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: next address in program order, deferred targets, halt.
  logic [31:0] exp_pc;
  logic [31:0] sched[$];
  logic        m_halt;

  // What the DUT saw / showed in the cycle before the latest edge.
  logic        p_rst, p_read, p_wait, p_valid, p_ready, p_rv, p_idle;
  logic [31:0] p_rt, p_instr, p_ipc, p_addr;
  logic        idle_now;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h00221820;
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RV;
    sched.delete();
    m_halt = 1'b0;
  endtask

  task automatic model_accept(input logic rv, input logic [31:0] rt);
    logic [31:0] t;
    if (sched.size() != 0) begin
      t = sched.pop_front();
      if (t == 32'd0) m_halt = 1'b1;
      else exp_pc = t;
    end else begin
      exp_pc = exp_pc + 32'd4;
      if (rv) sched.push_back({rt[31:2], 2'b00});
    end
  endtask

  task automatic check_cycle();
    logic [31:0] w;
    idle_now = 1'b0;
    if (p_rst) begin
      model_reset();
      idle_now = 1'b1;
      chk("rst_addr",   mem_address, RV);
      chk("rst_read",   32'(mem_read), 32'd0);
      chk("rst_valid",  32'(instr_valid), 32'd0);
      chk("rst_instr",  instr, 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_ipc",    instr_pc, 32'd0);
    end else if (p_idle) begin
      chk("first_read", 32'(mem_read), 32'd1);
      chk("first_addr", mem_address, exp_pc);
    end else if (p_read && !p_wait) begin
      w = memword(exp_pc);
      chk("cap_valid",  32'(instr_valid), 32'd1);
      chk("cap_read",   32'(mem_read), 32'd0);
      chk("cap_instr",  instr, w);
      chk("cap_opcode", 32'(opcode), 32'(w[31:26]));
      chk("cap_ipc",    instr_pc, exp_pc);
    end else if (p_read) begin
      chk("wait_read",  32'(mem_read), 32'd1);
      chk("wait_addr",  mem_address, exp_pc);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end else if (p_valid && !p_ready) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_read",  32'(mem_read), 32'd0);
      chk("hold_instr", instr, p_instr);
      chk("hold_ipc",   instr_pc, p_ipc);
    end else if (p_valid) begin
      model_accept(p_rv, p_rt);
      chk("acc_valid", 32'(instr_valid), 32'd0);
      chk("acc_read",  32'(mem_read), m_halt ? 32'd0 : 32'd1);
      chk("acc_addr",  mem_address, exp_pc);
    end else begin
      chk("halt_read",  32'(mem_read), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_addr",  mem_address, p_addr);
    end
    chk("active", 32'(active), 32'(mem_read | instr_valid));
  endtask

  task automatic step(input logic rst, input logic w, input logic r,
                      input logic rv, input logic [31:0] rt);
    reset           = rst;
    mem_waitrequest = w;
    instr_ready     = r;
    redirect_valid  = rv;
    redirect_target = rt;
    p_rst   = rst;   p_read  = mem_read;    p_wait = w;
    p_valid = instr_valid; p_ready = r;     p_rv   = rv;
    p_rt    = rt;    p_idle  = idle_now;    p_instr = instr;
    p_ipc   = instr_pc; p_addr = mem_address;
    @(posedge clk);
    #1;
    mem_readdata = memword(mem_address);
    check_cycle();
  endtask

  task automatic run(input logic w, input logic r, input logic rv, input logic [31:0] rt);
    step(1'b0, w, r, rv, rt);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  int unsigned halt_cnt;

  initial begin
    reset = 1'b1; mem_waitrequest = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; mem_readdata = '0;
    idle_now = 1'b0;
    model_reset();

    // Basic fetch/issue timing.
    do_reset();
    run(0, 1, 0, 0);
    chk("t1_read_c2", 32'(mem_read), 32'd1);
    chk("t1_addr_c2", mem_address, 32'hBFC00000);
    run(0, 1, 0, 0);
    chk("t1_instr", instr, 32'h00221820);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    run(0, 1, 0, 0);
    chk("t1_next", mem_address, 32'hBFC00004);

    // Wait states, then a stalled consumer.
    do_reset();
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    chk("t2_valid_low", 32'(instr_valid), 32'd0);
    run(0, 0, 0, 0);
    chk("t2_capture", instr, 32'h00221820);
    for (int i = 0; i < 5; i++) run(0, 0, 1, 32'h1234);
    chk("t3_held", instr_pc, 32'hBFC00000);
    run(0, 1, 0, 0);
    chk("t3_next", mem_address, 32'hBFC00004);

    // Jump with delay slot.
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 0, 0);
    run(0, 1, 1, 32'hBFC00103);
    chk("t4_slot", mem_address, 32'hBFC0000C);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    chk("t4_target", mem_address, 32'hBFC00100);

    // Jump to 0 (low bits masked) halts after the slot.
    run(0, 0, 0, 0);
    run(0, 1, 1, 32'h00000003);
    chk("t5_slot", mem_address, 32'hBFC00104);
    run(0, 0, 0, 0);
    chk("t5_slot_pc", instr_pc, 32'hBFC00104);
    run(0, 1, 0, 0);
    chk("t5_halt_active", 32'(active), 32'd0);
    for (int i = 0; i < 6; i++) run(1'($urandom_range(0, 1)), 1, 1, $urandom);
    chk("t5_frozen", mem_address, 32'hBFC00104);

    // Reset from HALTED, then reset during a slot fetch with waitrequest.
    do_reset();
    chk("t6_restart", mem_address, RV);
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);
    run(0, 1, 1, 32'h00001000);
    run(1, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("t6_abandon", 32'(mem_read), 32'd0);
    run(0, 0, 0, 0);
    chk("t6_refetch", mem_address, RV);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    chk("t6_pend_clr", mem_address, 32'hBFC00008);
    run(0, 0, 0, 0);
    run(0, 1, 1, 32'h00002000);
    run(0, 0, 0, 0);
    run(0, 1, 1, 32'h00003000);
    chk("t6_first_tgt", mem_address, 32'h00002000);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    chk("t6_ignored", mem_address, 32'h00002004);

    // pc wrap.
    run(0, 0, 0, 0);
    run(0, 1, 1, 32'hFFFFFFF8);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    chk("t7_top", mem_address, 32'hFFFFFFFC);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    chk("t7_wrap", mem_address, 32'h00000000);
    run(0, 0, 0, 0);
    chk("t7_wrap_ipc", instr_pc, 32'h00000000);

    // Randomized run.
    do_reset();
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rst, w, r, rv;
      logic [31:0] rt;
      rst = (halt_cnt > 4) || ($urandom_range(0, 299) == 0);
      w   = ($urandom_range(0, 2) == 0);
      r   = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) == 0);
      rt  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      step(rst, w, r, rv, rt);
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
